// File: rtl/spi_master_ctrl.sv
// SPI command master: serialises {ctrl, payload} MSB first, one bit per clk,
// and for read_data collects the returned byte after a fixed turnaround gap.
module spi_master_ctrl #(
  parameter int FRAME_WIDTH = 8,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [FRAME_WIDTH-1:0] cmd_data,
  output logic                   rsp_valid,
  output logic [FRAME_WIDTH-1:0] rsp_data,
  output logic                   busy,
  output logic                   SS_n,
  output logic                   MOSI,
  input  logic                   MISO
);

  localparam int CTRL_WIDTH = 3;
  localparam int TOTAL      = CTRL_WIDTH + FRAME_WIDTH;
  localparam int BW         = $clog2(TOTAL);
  localparam int GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(TOTAL - 1);
  localparam logic [BW-1:0] RX_LAST  = BW'(FRAME_WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SHIFT,
    GAP,
    RECV,
    DESELECT
  } state_t;

  state_t                 state, state_next;
  logic [TOTAL-1:0]       tx_sh, tx_sh_next;
  logic                   is_read, is_read_next;
  logic [BW-1:0]          bit_cnt, bit_cnt_next;
  logic [GW-1:0]          gap_cnt, gap_cnt_next;
  // Holds only the first FRAME_WIDTH-1 received bits; the last bit is
  // merged straight from MISO when the response is registered.
  logic [FRAME_WIDTH-2:0] rx_sh, rx_sh_next;
  logic [FRAME_WIDTH-1:0] rx_full;
  logic [FRAME_WIDTH-1:0] rsp_data_next;
  logic                   rsp_valid_next;
  logic                   ss_n_next;
  logic                   mosi_next;

  assign rx_full   = {rx_sh, MISO};
  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

  always_comb begin
    state_next     = state;
    tx_sh_next     = tx_sh;
    is_read_next   = is_read;
    bit_cnt_next   = bit_cnt;
    gap_cnt_next   = gap_cnt;
    rx_sh_next     = rx_sh;
    rsp_data_next  = rsp_data;
    rsp_valid_next = 1'b0;
    mosi_next      = 1'b0;

    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_next   = SELECT;
          // ctrl: 00->000, 01->001, 10->110, 11->111
          tx_sh_next   = {cmd_op[1], cmd_op[1], cmd_op[0], cmd_data};
          is_read_next = &cmd_op;
          bit_cnt_next = '0;
          gap_cnt_next = '0;
        end
      end
      SELECT: begin
        state_next = SHIFT;
        mosi_next  = tx_sh[TOTAL-1];
        tx_sh_next = {tx_sh[TOTAL-2:0], 1'b0};
      end
      SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_next = '0;
          state_next   = is_read ? GAP : DESELECT;
        end else begin
          bit_cnt_next = bit_cnt + 1'b1;
          mosi_next    = tx_sh[TOTAL-1];
          tx_sh_next   = {tx_sh[TOTAL-2:0], 1'b0};
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = RECV;
        end else begin
          gap_cnt_next = gap_cnt + 1'b1;
        end
      end
      RECV: begin
        if (bit_cnt == RX_LAST) begin
          state_next     = DESELECT;
          bit_cnt_next   = '0;
          rsp_valid_next = 1'b1;
          rsp_data_next  = rx_full;
        end else begin
          bit_cnt_next = bit_cnt + 1'b1;
          rx_sh_next   = rx_full[FRAME_WIDTH-2:0];
        end
      end
      DESELECT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    ss_n_next = !(state_next inside {SELECT, SHIFT, GAP, RECV});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_sh     <= '0;
      is_read   <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      rx_sh     <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
    end else begin
      state     <= state_next;
      tx_sh     <= tx_sh_next;
      is_read   <= is_read_next;
      bit_cnt   <= bit_cnt_next;
      gap_cnt   <= gap_cnt_next;
      rx_sh     <= rx_sh_next;
      rsp_data  <= rsp_data_next;
      rsp_valid <= rsp_valid_next;
      SS_n      <= ss_n_next;
      MOSI      <= mosi_next;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl with a behavioural SPI slave + RAM on the pins.
module tb_spi_master_ctrl;

  localparam int FW  = 8;
  localparam int GAP = 2;
  localparam int TOT = 3 + FW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [FW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic [FW-1:0] rsp_data;
  logic          busy;
  logic          SS_n;
  logic          MOSI;
  logic          MISO = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.FRAME_WIDTH(FW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  // Slave model: counts SS_n-low cycles, decodes the frame, serves reads.
  logic [7:0]  slave_mem [256];
  logic [7:0]  s_waddr = '0;
  logic [7:0]  s_raddr = '0;
  logic [10:0] s_frame = '0;
  logic [7:0]  s_byte;
  logic        s_read = 1'b0;
  int          s_cnt = 0;

  always @(negedge clk) begin
    if (SS_n !== 1'b0) begin
      s_cnt  = 0;
      s_read = 1'b0;
      MISO   = 1'b0;
    end else begin
      s_cnt = s_cnt + 1;
      if (s_cnt >= 2 && s_cnt <= TOT + 1) s_frame[TOT + 1 - s_cnt] = MOSI;
      if (s_cnt == TOT + 1) begin
        case (s_frame[10:8])
          3'b000:  s_waddr = s_frame[7:0];
          3'b001:  slave_mem[s_waddr] = s_frame[7:0];
          3'b110:  s_raddr = s_frame[7:0];
          3'b111:  s_read = 1'b1;
          default: ;
        endcase
      end
      MISO = 1'b0;
      if (s_read && s_cnt >= TOT + 2 + GAP && s_cnt < TOT + 2 + GAP + FW) begin
        s_byte = slave_mem[s_raddr];
        MISO   = s_byte[TOT + 1 + GAP + FW - s_cnt];
      end
    end
  end

  function automatic logic [10:0] ref_frame(input logic [1:0] op, input logic [7:0] d);
    logic [2:0] ctrl;
    case (op)
      2'd0:    ctrl = 3'b000;
      2'd1:    ctrl = 3'b001;
      2'd2:    ctrl = 3'b110;
      default: ctrl = 3'b111;
    endcase
    return {ctrl, d};
  endfunction

  // Per-cycle traces, index = cycle number after acceptance.
  logic       ss_tr  [64];
  logic       mosi_tr[64];
  logic       rv_tr  [64];
  logic       rdy_tr [64];
  logic [7:0] rd_tr  [64];

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input int ncyc,
                        output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = 8'($urandom);
        ok        = 1'b1;
      end
    end
    if (ok) begin
      for (int n = 1; n <= ncyc; n++) begin
        if (n > 1) begin
          @(posedge clk);
          #1;
        end
        ss_tr[n]   = SS_n;
        mosi_tr[n] = MOSI;
        rv_tr[n]   = rsp_valid;
        rdy_tr[n]  = cmd_ready;
        rd_tr[n]   = rsp_data;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({SS_n, MOSI, cmd_ready, busy, rsp_valid, rsp_data} !== {4'b1010, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_async: got ss=%b mosi=%b rdy=%b busy=%b rv=%b rd=%h want 1 0 1 0 0 00",
               SS_n, MOSI, cmd_ready, busy, rsp_valid, rsp_data);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({SS_n, MOSI, cmd_ready, rsp_valid} !== 4'b1010) begin
      bad++;
      $display("FAIL reset_hold: got ss=%b mosi=%b rdy=%b rv=%b want 1 0 1 0",
               SS_n, MOSI, cmd_ready, rsp_valid);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_write_addr();
    bit ok;
    logic [10:0] f;
    f = ref_frame(2'd0, 8'h5A);
    do_cmd(2'd0, 8'h5A, 14, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wr_accept: got timeout want accepted");
      return;
    end
    for (int n = 1; n <= 14; n++) begin
      logic es, em;
      es = (n <= TOT + 1) ? 1'b0 : 1'b1;
      em = (n >= 2 && n <= TOT + 1) ? f[TOT + 1 - n] : 1'b0;
      total++;
      if (ss_tr[n] !== es || mosi_tr[n] !== em) begin
        bad++;
        $display("FAIL wr_pins cycle %0d: got ss=%b mosi=%b want ss=%b mosi=%b",
                 n, ss_tr[n], mosi_tr[n], es, em);
      end
      total++;
      if (rdy_tr[n] !== (n == 14) || rv_tr[n] !== 1'b0) begin
        bad++;
        $display("FAIL wr_ctrl cycle %0d: got rdy=%b rv=%b want rdy=%b rv=0",
                 n, rdy_tr[n], rv_tr[n], (n == 14));
      end
    end
  endtask

  task automatic test_read_data();
    bit ok;
    logic [10:0] f;
    int last;
    last = TOT + 2 + GAP + FW;  // cycle carrying rsp_valid
    slave_mem[s_raddr] = 8'hC3;
    f = ref_frame(2'd3, 8'hFF);
    do_cmd(2'd3, 8'hFF, last + 1, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rd_accept: got timeout want accepted");
      return;
    end
    for (int n = 1; n <= last + 1; n++) begin
      logic es, em;
      es = (n < last) ? 1'b0 : 1'b1;
      em = (n >= 2 && n <= TOT + 1) ? f[TOT + 1 - n] : 1'b0;
      total++;
      if (ss_tr[n] !== es || mosi_tr[n] !== em) begin
        bad++;
        $display("FAIL rd_pins cycle %0d: got ss=%b mosi=%b want ss=%b mosi=%b",
                 n, ss_tr[n], mosi_tr[n], es, em);
      end
      total++;
      if (rv_tr[n] !== (n == last) || rdy_tr[n] !== (n == last + 1)) begin
        bad++;
        $display("FAIL rd_ctrl cycle %0d: got rv=%b rdy=%b want rv=%b rdy=%b",
                 n, rv_tr[n], rdy_tr[n], (n == last), (n == last + 1));
      end
    end
    total++;
    if (rd_tr[last] !== 8'hC3) begin
      bad++;
      $display("FAIL rd_data: got %h want c3", rd_tr[last]);
    end
    do_cmd(2'd0, 8'($urandom), 14, ok);
    total++;
    if (!ok || rd_tr[14] !== 8'hC3 || rsp_data !== 8'hC3) begin
      bad++;
      $display("FAIL rd_hold: got %h want c3 (ok=%0d)", rsp_data, ok);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    int acc2;
    logic [10:0] f1, f2;
    f1 = ref_frame(2'd1, 8'h01);
    f2 = ref_frame(2'd2, 8'h10);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_data  = 8'h01;
        got       = 1'b1;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL b2b_accept: got timeout want accepted");
      return;
    end
    @(posedge clk);
    #1;
    cmd_op   = 2'd2;
    cmd_data = 8'h10;
    acc2 = 0;
    for (int n = 1; n <= 56; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
        if (acc2 != 0) cmd_valid = 1'b0;
      end
      ss_tr[n]   = SS_n;
      mosi_tr[n] = MOSI;
      if (cmd_ready === 1'b1 && acc2 == 0) acc2 = n;
    end
    cmd_valid = 1'b0;
    total++;
    if (acc2 != 14) begin
      bad++;
      $display("FAIL b2b_second_accept: got cycle %0d want 14", acc2);
      if (acc2 == 0 || acc2 > 40) return;
    end
    total++;
    if (ss_tr[13] !== 1'b1 || ss_tr[acc2] !== 1'b1 || ss_tr[acc2 + 1] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ss_gap: got ss13=%b ss%0d=%b ss%0d=%b want 1 1 0",
               ss_tr[13], acc2, ss_tr[acc2], acc2 + 1, ss_tr[acc2 + 1]);
    end
    for (int k = 0; k < TOT; k++) begin
      total++;
      if (mosi_tr[2 + k] !== f1[TOT - 1 - k] || mosi_tr[acc2 + 2 + k] !== f2[TOT - 1 - k]) begin
        bad++;
        $display("FAIL b2b_frame bit %0d: got %b/%b want %b/%b", TOT - 1 - k,
                 mosi_tr[2 + k], mosi_tr[acc2 + 2 + k], f1[TOT - 1 - k], f2[TOT - 1 - k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen_rv;
    do_cmd(2'd0, 8'h33, 7, ok);
    total++;
    if (!ok || ss_tr[7] !== 1'b0 || mosi_tr[7] !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: got ss=%b mosi=%b want 0 1 (ok=%0d)", ss_tr[7], mosi_tr[7], ok);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({SS_n, MOSI, cmd_ready, busy} !== 4'b1010) begin
      bad++;
      $display("FAIL mid_abort: got ss=%b mosi=%b rdy=%b busy=%b want 1 0 1 0",
               SS_n, MOSI, cmd_ready, busy);
    end
    @(negedge clk) rst_n = 1'b1;
    seen_rv = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || SS_n !== 1'b1) seen_rv = 1'b1;
    end
    total++;
    if (seen_rv || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_after: got stray=%b rdy=%b want 0 1", seen_rv, cmd_ready);
    end
  endtask

  task automatic test_integration();
    bit ok0, ok1, ok2, ok3;
    logic [7:0] a, d;
    int last;
    last = TOT + 2 + GAP + FW;
    for (int t = 0; t < 11; t++) begin
      if (t == 0) begin
        a = 8'h10;
        d = 8'hA5;
      end else begin
        a = 8'($urandom);
        d = 8'($urandom);
      end
      do_cmd(2'd0, a, 14, ok0);
      do_cmd(2'd1, d, 14, ok1);
      do_cmd(2'd2, a, 14, ok2);
      do_cmd(2'd3, 8'($urandom), last + 1, ok3);
      total++;
      if (!(ok0 && ok1 && ok2 && ok3) || rv_tr[last] !== 1'b1 || rd_tr[last] !== d) begin
        bad++;
        $display("FAIL integ_read[%0d] addr %h: got rv=%b data=%h want rv=1 data=%h",
                 t, a, rv_tr[last], rd_tr[last], d);
      end
      total++;
      if (slave_mem[a] !== d) begin
        bad++;
        $display("FAIL integ_ram[%0d] addr %h: got %h want %h", t, a, slave_mem[a], d);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) slave_mem[i] = 8'h00;
    test_reset();
    test_write_addr();
    test_read_data();
    test_back_to_back();
    test_reset_mid();
    test_integration();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
